// File: rtl/score_pkg.sv
// score_pkg: shared constants, FSM state type and digit-blanking helper
// for the score_keeper block.
//   SCORE_W     binary score width
//   MAX_SCORE   saturation ceiling
//   NDIGITS     number of BCD digits produced
//   BLANK_DIGIT code the display renders as an unlit digit
//   BCD_RESET   reset value of the latched digits; depends on the
//               SCORE_LEADING_BLANK_EN build macro
package score_pkg;

    localparam int SCORE_W   = 17;
    localparam int MAX_SCORE = 99999;
    localparam int NDIGITS   = 5;
    localparam int BCD_W     = 4 * NDIGITS;
    localparam int ITER_W    = $clog2(SCORE_W);

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

`ifdef SCORE_LEADING_BLANK_EN
    localparam logic [BCD_W-1:0] BCD_RESET = {{(NDIGITS-1){BLANK_DIGIT}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] BCD_RESET = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } score_state_t;

    // Replace leading zero digits with BLANK_DIGIT. The least significant
    // digit is always shown so that a score of 0 still renders as "0".
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic             lead;
        logic [BCD_W-1:0] r;
        r    = bcd;
        lead = 1'b1;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = BLANK_DIGIT;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: game-event inputs and display-side outputs of score_keeper.
//   frame_start  one-cycle per-frame conversion request
//   clear        synchronous score clear (wins over add_valid)
//   add_valid    qualifies add_pts
//   add_pts      unsigned points to add
//   score        live binary score
//   score_bcd    latched BCD digits, [19:16] most significant
//   bcd_valid    set once the first conversion has completed
//   busy         conversion in flight
// modport master: event source / testbench side; modport slave: score_keeper.
interface score_keeper_if;
    import score_pkg::*;

    logic               frame_start;
    logic               clear;
    logic               add_valid;
    logic [7:0]         add_pts;
    logic [SCORE_W-1:0] score;
    logic [BCD_W-1:0]   score_bcd;
    logic               bcd_valid;
    logic               busy;

    modport master (
        output frame_start, clear, add_valid, add_pts,
        input  score, score_bcd, bcd_valid, busy
    );

    modport slave (
        input  frame_start, clear, add_valid, add_pts,
        output score, score_bcd, bcd_valid, busy
    );

endinterface

// File: rtl/score_keeper_dabble_adj.sv
// dabble_adj: combinational double-dabble correction step. Every BCD nibble
// that is 5 or more gets 3 added so the following left shift carries
// correctly into the next decimal digit.
//   bcd_i  working BCD vector before correction
//   bcd_o  corrected BCD vector
module dabble_adj
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [BCD_W-1:0] bcd_o
);

    for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
        assign bcd_o[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? bcd_i[4*g +: 4] + 4'd3
                                                           : bcd_i[4*g +: 4];
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: saturating score accumulator plus a once-per-frame sequential
// double-dabble binary-to-BCD converter. The latched digits only change when a
// conversion completes, so the display never sees a half-updated value.
// Build option: SCORE_LEADING_BLANK_EN blanks leading zero digits (4'hF).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; aborts any conversion
//   bus    score_keeper_if.slave (events in, score / digits / status out)
module score_keeper
    import score_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    score_keeper_if.slave  bus
);

    score_state_t       state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [BCD_W-1:0]   score_bcd_q, score_bcd_d;
    logic               bcd_valid_q, bcd_valid_d;

    logic [SCORE_W:0]           sum;
    logic [BCD_W-1:0]           work_adj;
    logic [BCD_W+SCORE_W-1:0]   shifted;

    dabble_adj u_adj (
        .bcd_i (work_q),
        .bcd_o (work_adj)
    );

    // Accumulator: one extra bit so the saturation compare sees the true sum.
    always_comb begin
        sum     = {1'b0, score_q} + (SCORE_W+1)'(bus.add_pts);
        score_d = score_q;
        if (bus.clear) begin
            score_d = '0;
        end else if (bus.add_valid) begin
            score_d = (sum > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                     : sum[SCORE_W-1:0];
        end
    end

    // Converter FSM.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        work_d      = work_q;
        iter_d      = iter_q;
        score_bcd_d = score_bcd_q;
        bcd_valid_d = bcd_valid_q;
        shifted     = {work_adj, bin_q} << 1;

        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    bin_d   = score_q;
                    work_d  = '0;
                    iter_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {work_d, bin_d} = shifted;
                iter_d          = iter_q + 1'b1;
                if (iter_q == ITER_W'(SCORE_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef SCORE_LEADING_BLANK_EN
                score_bcd_d = blank_leading(work_q);
`else
                score_bcd_d = work_q;
`endif
                bcd_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            bin_q       <= '0;
            work_q      <= '0;
            iter_q      <= '0;
            score_bcd_q <= BCD_RESET;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            iter_q      <= iter_d;
            score_bcd_q <= score_bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bus.score     = score_q;
    assign bus.score_bcd = score_bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed self-checking bench for score_keeper.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_score_keeper;
    import score_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

`ifdef SCORE_LEADING_BLANK_EN
    localparam logic [19:0] E_ZERO = 20'hFFFF0;
    localparam logic [19:0] E_264  = 20'hFF264;
    localparam logic [19:0] E_123  = 20'hFF123;
`else
    localparam logic [19:0] E_ZERO = 20'h00000;
    localparam logic [19:0] E_264  = 20'h00264;
    localparam logic [19:0] E_123  = 20'h00123;
`endif

    score_keeper_if bus ();

    score_keeper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [7:0] pts, input int n);
        for (int i = 0; i < n; i++) begin
            bus.add_valid = 1'b1;
            bus.add_pts   = pts;
            @(negedge clk);
        end
        bus.add_valid = 1'b0;
        bus.add_pts   = '0;
    endtask

    // Pulse frame_start and count falling edges on which busy is high.
    task automatic convert(output int n);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.clear       = 1'b0;
        bus.add_valid   = 1'b0;
        bus.add_pts     = '0;
        repeat (3) @(negedge clk);

        chk("rst_score",     32'(bus.score),     32'd0);
        chk("rst_bcd",       32'(bus.score_bcd), 32'(E_ZERO));
        chk("rst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First conversion of a zero score.
        convert(cyc);
        chk("conv0_busy_cycles", 32'(cyc),           32'd18);
        chk("conv0_bcd",         32'(bus.score_bcd), 32'(E_ZERO));
        chk("conv0_valid",       32'(bus.bcd_valid), 32'd1);

        // Back-to-back adds.
        add(8'd200, 1);
        add(8'd55, 1);
        add(8'd9, 1);
        chk("add_score_264", 32'(bus.score), 32'd264);
        convert(cyc);
        chk("conv264_busy_cycles", 32'(cyc),           32'd18);
        chk("conv264_bcd",         32'(bus.score_bcd), 32'(E_264));

        // Saturation: 264 + 391*255 + 21 = 99990.
        add(8'd255, 391);
        add(8'd21, 1);
        chk("pre_sat_score", 32'(bus.score), 32'd99990);
        add(8'd50, 1);
        chk("sat_score", 32'(bus.score), 32'd99999);
        convert(cyc);
        chk("conv_sat_bcd", 32'(bus.score_bcd), 32'h99999);
        add(8'd255, 1);
        chk("sat_hold", 32'(bus.score), 32'd99999);

        // Clear, then build 12345 = 48*255 + 105.
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_score",    32'(bus.score),     32'd0);
        chk("clear_keep_bcd", 32'(bus.score_bcd), 32'h99999);
        add(8'd255, 48);
        add(8'd105, 1);
        chk("score_12345", 32'(bus.score), 32'd12345);

        // Snapshot isolation and a dropped mid-conversion pulse.
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        cyc = 1;
        add(8'd10, 1);
        repeat (3) @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        cyc = 5;
        while (bus.busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk("snap_busy_cycles", 32'(cyc),           32'd18);
        chk("snap_bcd",         32'(bus.score_bcd), 32'h12345);
        chk("snap_live_score",  32'(bus.score),     32'd12355);
        @(negedge clk);
        chk("dropped_pulse_idle", 32'(bus.busy), 32'd0);
        convert(cyc);
        chk("next_frame_bcd", 32'(bus.score_bcd), 32'h12355);

        // clear beats add_valid in the same cycle.
        bus.clear     = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_pts   = 8'd7;
        @(negedge clk);
        bus.clear     = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_pts   = '0;
        chk("clear_prio_score", 32'(bus.score),     32'd0);
        chk("clear_prio_bcd",   32'(bus.score_bcd), 32'h12355);
        chk("clear_prio_valid", 32'(bus.bcd_valid), 32'd1);
        convert(cyc);
        chk("clear_conv_bcd", 32'(bus.score_bcd), 32'(E_ZERO));

        // Reset during SHIFT around iteration 8.
        add(8'd200, 1);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  32'(bus.busy),      32'd0);
        chk("abort_bcd",   32'(bus.score_bcd), 32'(E_ZERO));
        chk("abort_valid", 32'(bus.bcd_valid), 32'd0);
        chk("abort_score", 32'(bus.score),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add(8'd123, 1);
        convert(cyc);
        chk("post_abort_cycles", 32'(cyc),           32'd18);
        chk("post_abort_bcd",    32'(bus.score_bcd), 32'(E_123));
        chk("post_abort_valid",  32'(bus.bcd_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Accumulates the player score from game events, saturates at 99999, and converts it once per frame to five BCD digits using a sequential double-dabble. It sits directly upstream of the score display stage, which draws five digits from `score_bcd`. The output digits change only at conversion completion, so the display never sees a half-updated value mid-frame.

## Interface
- `SCORE_W`, 17: binary score width.
- `MAX_SCORE`, 99999: saturation ceiling.
- `NDIGITS`, 5: BCD digits produced.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse per video frame; requests a conversion.
- `clear` in 1: synchronous score clear.
- `add_valid` in 1: qualifies `add_pts`.
- `add_pts` in 8: points to add, unsigned.
- `score` out `SCORE_W`: live binary score.
- `score_bcd` out `4*NDIGITS`: latched digits. [19:16] is the most significant digit.
- `bcd_valid` out 1: set after the first completed conversion.
- `busy` out 1: a conversion is in flight.

## Operation
- **Accumulator**
  - `clear` has priority over `add_valid`. If both are high in the same cycle, `score` becomes 0.
  - On `add_valid`, compute `score + add_pts` at `SCORE_W+1` bits. If the sum exceeds `MAX_SCORE`, `score` becomes `MAX_SCORE`; otherwise it becomes the sum.
  - Accumulation is independent of conversion.
- **FSM states:** IDLE, SHIFT, DONE.
  - **IDLE:** on `frame_start`, snapshot `score` into the shift register, zero the BCD working register, set `iter` to 0, and go to SHIFT.
  - **SHIFT:** each cycle, add 3 to every BCD nibble ≥ 5, then shift the {bcd, bin} register left by 1 and increment `iter`. When `iter` reaches `SCORE_W`-1, go to DONE.
  - **DONE:** copy the working BCD to `score_bcd`, set `bcd_valid`, and return to IDLE.
- `busy` is high whenever the state is not IDLE.
- `frame_start` is ignored while `busy`.
- Points added during a conversion do not affect the in-flight snapshot. They appear in the next frame's conversion.
- `clear` does not alter `score_bcd` or `bcd_valid`. The next conversion shows 0.

## Timing
- **Reset values:** `score` = 0, `score_bcd` = 0 (0xFFFF0 with blanking enabled), `bcd_valid` = 0, `busy` = 0, state IDLE.
- **Latency:**
  - `frame_start` is sampled at edge E.
  - SHIFT iterations occur at edges E+1 through E+17.
  - `score_bcd` updates at edge E+18 and is visible in the cycle after.
  - `busy` is high from E+1 through E+18, 18 cycles.
- **Accumulator latency:** `add_valid` at edge E updates `score` at edge E, visible in the next cycle. Back-to-back adds every cycle are supported.
- **Reset mid-conversion:** the conversion is aborted and all outputs return to their reset values. No partial digits are ever latched.
- **Pulse spacing:** `frame_start` pulses at most once per 19 cycles are guaranteed to be serviced. Others are dropped silently.

## Configuration
- **`SCORE_LEADING_BLANK_EN` defined:**
  - In DONE, leading zero digits are replaced by 4'hF, the blank code the display renders as black.
  - The least significant digit is never blanked, so a score of 0 shows as 0xFFFF0.
- **`SCORE_LEADING_BLANK_EN` undefined:** all five digits are output as plain BCD, so a score of 0 shows as 0x00000.

## Structure
- **`score_pkg`** holds:
  - `SCORE_W`, `MAX_SCORE`, `NDIGITS`
  - `BLANK_DIGIT` = 4'hF
  - the FSM state enum `score_state_t`
- **`dabble_adj`** is the one combinational sub-module. It takes the `4*NDIGITS` BCD vector and applies add-3 to each nibble ≥ 5. It is instantiated once, in the SHIFT path.

## Test plan
- Reset, then `frame_start` → `busy` high for 18 cycles; `score_bcd` = 0x00000 (0xFFFF0 with blanking); `bcd_valid` = 1.
- Adds 200, 55, and 9 on consecutive cycles, then `frame_start` → `score` = 264; after 18 cycles `score_bcd` = 0x00264 (0xFF264 with blanking).
- `score` preloaded to 99990 via adds, then `add_pts` = 50 → `score` = 99999; conversion → 0x99999. A further add leaves `score` at 99999.
- `frame_start` with `score` = 12345, then add 10 during SHIFT, plus a second `frame_start` pulse mid-conversion → `score_bcd` = 0x12345 and the second pulse is ignored; the next frame yields 0x12355.
- `clear` and `add_valid` (`add_pts` = 7) in the same cycle → `score` = 0; `score_bcd` keeps its old value until the next conversion.
- `rst_n` asserted at SHIFT iteration 8 → `busy` = 0 and `score_bcd` = reset value immediately; the next conversion completes correctly.
